// File: rtl/exc_pkg.sv
// rtl/exc_pkg.sv - shared constants and FSM state type for the exception/interrupt sequencer
//
// Purpose : ECODE values, WB exception flag bit positions and sequencer state encoding.
// Ports   : none (package)
package exc_pkg;

   localparam int INT_W = 13;
   localparam int EXC_W = 5;

   // Bit positions inside the ws_exc flag vector
   localparam int EXC_ADEF = 0;
   localparam int EXC_INE  = 1;
   localparam int EXC_SYS  = 2;
   localparam int EXC_BRK  = 3;
   localparam int EXC_ALE  = 4;

   // Interrupt line that never qualifies as a pending interrupt
   localparam int INT_MASKED_BIT = 10;

   localparam logic [5:0] ECODE_INT  = 6'h00;
   localparam logic [5:0] ECODE_ADEF = 6'h08;
   localparam logic [5:0] ECODE_ALE  = 6'h09;
   localparam logic [5:0] ECODE_SYS  = 6'h0B;
   localparam logic [5:0] ECODE_BRK  = 6'h0C;
   localparam logic [5:0] ECODE_INE  = 6'h0D;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_COMMIT   = 2'd1,
      ST_WAIT_ACK = 2'd2
   } state_e;

endpackage

// File: rtl/exc_prio_enc.sv
// rtl/exc_prio_enc.sv - interrupt qualification and exception priority encoder
//
// Purpose : combinational; qualifies interrupts and picks the highest-priority event.
// Ports   : crmd_ie_i, estat_is_i, ecfg_lie_i  interrupt enable / status / local enable
//           exc_i                              WB exception flags
//           hit_o                              an interrupt or exception is present
//           ecode_o, esubcode_o                codes of the winning event
//           is_int_o                           winning event is an interrupt
module exc_prio_enc
   import exc_pkg::*;
#(
   parameter int INT_W = 13,
   parameter int EXC_W = 5
) (
   input  logic             crmd_ie_i,
   input  logic [INT_W-1:0] estat_is_i,
   input  logic [INT_W-1:0] ecfg_lie_i,
   input  logic [EXC_W-1:0] exc_i,
   output logic             hit_o,
   output logic [5:0]       ecode_o,
   output logic [8:0]       esubcode_o,
   output logic             is_int_o
);

   logic [INT_W-1:0] int_mask;
   logic             int_pend;

   assign int_mask   = ~(INT_W'(1) << INT_MASKED_BIT);
   assign int_pend   = crmd_ie_i & (|(estat_is_i & ecfg_lie_i & int_mask));
   assign esubcode_o = 9'd0;

   always_comb begin
      hit_o    = 1'b1;
      ecode_o  = ECODE_INT;
      is_int_o = 1'b0;
      if (int_pend) begin
         is_int_o = 1'b1;
      end else if (exc_i[EXC_ADEF]) begin
         ecode_o = ECODE_ADEF;
      end else if (exc_i[EXC_INE]) begin
         ecode_o = ECODE_INE;
      end else if (exc_i[EXC_SYS]) begin
         ecode_o = ECODE_SYS;
      end else if (exc_i[EXC_BRK]) begin
         ecode_o = ECODE_BRK;
      end else if (exc_i[EXC_ALE]) begin
         ecode_o = ECODE_ALE;
      end else begin
         hit_o = 1'b0;
      end
   end

endmodule

// File: rtl/exc_int_ctrl.sv
// rtl/exc_int_ctrl.sv - exception/interrupt sequencer between WB and the CSR file
//
// Purpose : commits one exception or ERTN per event into the CSR file and runs a
//           flush + redirect handshake with fetch, holding WB off until acknowledged.
// Ports   : clk, reset                      clock, synchronous active-high reset
//           ws_valid/pc/exc/vaddr/ertn      WB instruction and its exception info
//           csr_crmd_ie/estat_is/ecfg_lie   interrupt qualification inputs
//           csr_eentry, csr_era             redirect targets
//           ws_allowin                      WB may retire
//           wb_ex/ecode/esubcode/pc/vaddr   exception commit to CSR file
//           ertn_flush                      ERTN commit to CSR file
//           flush_req, redirect_pc          redirect request to fetch
//           redirect_ack                    fetch accepted the redirect
module exc_int_ctrl
   import exc_pkg::*;
#(
   parameter int INT_W = 13,
   parameter int EXC_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ws_valid,
   input  logic [31:0]      ws_pc,
   input  logic [EXC_W-1:0] ws_exc,
   input  logic [31:0]      ws_vaddr,
   input  logic             ws_ertn,
   input  logic             csr_crmd_ie,
   input  logic [INT_W-1:0] csr_estat_is,
   input  logic [INT_W-1:0] csr_ecfg_lie,
   input  logic [31:0]      csr_eentry,
   input  logic [31:0]      csr_era,
   output logic             ws_allowin,
   output logic             wb_ex,
   output logic [5:0]       wb_ecode,
   output logic [8:0]       wb_esubcode,
   output logic [31:0]      wb_pc,
   output logic [31:0]      wb_vaddr,
   output logic             ertn_flush,
   output logic             flush_req,
   output logic [31:0]      redirect_pc,
   input  logic             redirect_ack
);

   state_e      state_q, state_d;
   logic [5:0]  ecode_q, ecode_d;
   logic [8:0]  esub_q, esub_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] vaddr_q, vaddr_d;
   logic        ertn_q, ertn_d;
   logic [31:0] redir_q, redir_d;

   logic        enc_hit;
   logic [5:0]  enc_ecode;
   logic [8:0]  enc_esub;
   logic        enc_is_int;
   logic        event_det;

   exc_prio_enc #(.INT_W(INT_W), .EXC_W(EXC_W)) u_prio (
      .crmd_ie_i  (csr_crmd_ie),
      .estat_is_i (csr_estat_is),
      .ecfg_lie_i (csr_ecfg_lie),
      .exc_i      (ws_exc),
      .hit_o      (enc_hit),
      .ecode_o    (enc_ecode),
      .esubcode_o (enc_esub),
      .is_int_o   (enc_is_int)
   );

   // Interrupts need a valid WB instruction so ERA has something to point at
   assign event_det = ws_valid & (enc_hit | ws_ertn);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         ecode_q <= 6'd0;
         esub_q  <= 9'd0;
         pc_q    <= 32'd0;
         vaddr_q <= 32'd0;
         ertn_q  <= 1'b0;
         redir_q <= 32'd0;
      end else begin
         state_q <= state_d;
         ecode_q <= ecode_d;
         esub_q  <= esub_d;
         pc_q    <= pc_d;
         vaddr_q <= vaddr_d;
         ertn_q  <= ertn_d;
         redir_q <= redir_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      ecode_d     = ecode_q;
      esub_d      = esub_q;
      pc_d        = pc_q;
      vaddr_d     = vaddr_q;
      ertn_d      = ertn_q;
      redir_d     = redir_q;
      ws_allowin  = 1'b0;
      wb_ex       = 1'b0;
      ertn_flush  = 1'b0;
      flush_req   = 1'b0;
      redirect_pc = redir_q;

      unique case (state_q)
         ST_IDLE: begin
            ws_allowin = ~event_det;
            if (event_det) begin
               state_d = ST_COMMIT;
               // Any exception or interrupt outranks ERTN on the same instruction
               ertn_d  = ~enc_hit;
               ecode_d = enc_ecode;
               esub_d  = enc_esub;
               pc_d    = ws_pc;
               if (enc_hit && !enc_is_int && enc_ecode == ECODE_ADEF) begin
                  vaddr_d = ws_pc;
               end else if (enc_hit && !enc_is_int && enc_ecode == ECODE_ALE) begin
                  vaddr_d = ws_vaddr;
               end else begin
                  vaddr_d = 32'd0;
               end
            end
         end
         ST_COMMIT: begin
            wb_ex       = ~ertn_q;
            ertn_flush  = ertn_q;
            flush_req   = 1'b1;
            // Target is sampled now and held for the rest of the handshake
            redirect_pc = ertn_q ? csr_era : csr_eentry;
            redir_d     = redirect_pc;
            state_d     = redirect_ack ? ST_IDLE : ST_WAIT_ACK;
         end
         ST_WAIT_ACK: begin
            flush_req = 1'b1;
            if (redirect_ack) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign wb_ecode    = ecode_q;
   assign wb_esubcode = esub_q;
   assign wb_pc       = pc_q;
   assign wb_vaddr    = vaddr_q;

endmodule

// File: tb/tb_exc_int_ctrl.sv
// tb/tb_exc_int_ctrl.sv - self-checking bench for exc_int_ctrl
module tb_exc_int_ctrl;

   logic        clk;
   logic        reset;
   logic        ws_valid;
   logic [31:0] ws_pc;
   logic [4:0]  ws_exc;
   logic [31:0] ws_vaddr;
   logic        ws_ertn;
   logic        csr_crmd_ie;
   logic [12:0] csr_estat_is;
   logic [12:0] csr_ecfg_lie;
   logic [31:0] csr_eentry;
   logic [31:0] csr_era;
   logic        ws_allowin;
   logic        wb_ex;
   logic [5:0]  wb_ecode;
   logic [8:0]  wb_esubcode;
   logic [31:0] wb_pc;
   logic [31:0] wb_vaddr;
   logic        ertn_flush;
   logic        flush_req;
   logic [31:0] redirect_pc;
   logic        redirect_ack;

   int total;
   int bad;

   // Observations collected by drive_event
   logic        obs_allow_evt;
   int          obs_flush;
   int          obs_ex;
   int          obs_ertn;
   logic [5:0]  obs_ecode;
   logic [8:0]  obs_esub;
   logic [31:0] obs_pc;
   logic [31:0] obs_vaddr;
   logic [31:0] obs_redir;
   logic        obs_redir_stable;
   logic        obs_allow_hi;
   logic        obs_idle_allow;
   logic        obs_timeout;

   exc_int_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .ws_valid     (ws_valid),
      .ws_pc        (ws_pc),
      .ws_exc       (ws_exc),
      .ws_vaddr     (ws_vaddr),
      .ws_ertn      (ws_ertn),
      .csr_crmd_ie  (csr_crmd_ie),
      .csr_estat_is (csr_estat_is),
      .csr_ecfg_lie (csr_ecfg_lie),
      .csr_eentry   (csr_eentry),
      .csr_era      (csr_era),
      .ws_allowin   (ws_allowin),
      .wb_ex        (wb_ex),
      .wb_ecode     (wb_ecode),
      .wb_esubcode  (wb_esubcode),
      .wb_pc        (wb_pc),
      .wb_vaddr     (wb_vaddr),
      .ertn_flush   (ertn_flush),
      .flush_req    (flush_req),
      .redirect_pc  (redirect_pc),
      .redirect_ack (redirect_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: which event an instruction raises, from the priority rules
   function automatic void model(input logic valid, input logic [4:0] exc, input logic ertn,
                                 input logic ie, input logic [12:0] is, input logic [12:0] lie,
                                 input logic [31:0] pc, input logic [31:0] vaddr,
                                 output logic evt, output logic is_ertn,
                                 output logic [5:0] ecode, output logic [31:0] va);
      logic [5:0] codes [5];
      logic       pend;
      logic       found;
      codes[0] = 6'h08; codes[1] = 6'h0D; codes[2] = 6'h0B; codes[3] = 6'h0C; codes[4] = 6'h09;
      pend    = ie && ((is & lie & ~(13'd1 << 10)) != 13'd0);
      found   = 1'b0;
      ecode   = 6'h00;
      va      = 32'd0;
      if (pend) begin
         found = 1'b1;
      end else begin
         for (int i = 0; i < 5; i++) begin
            if (!found && exc[i]) begin
               found = 1'b1;
               ecode = codes[i];
               if (i == 0) va = pc;
               if (i == 4) va = vaddr;
            end
         end
      end
      evt     = valid && (found || ertn);
      is_ertn = evt && !found;
   endfunction

   // Presents one WB instruction (starting just after a rising edge) and records
   // what the DUT does until the flush handshake ends.
   task automatic drive_event(input logic v, input logic [31:0] pc, input logic [4:0] exc,
                              input logic [31:0] vaddr, input logic ertn, input logic ie,
                              input logic [12:0] is, input logic [12:0] lie,
                              input logic [31:0] eentry, input logic [31:0] era, input int delay);
      int  k;
      logic done;
      ws_valid = v; ws_pc = pc; ws_exc = exc; ws_vaddr = vaddr; ws_ertn = ertn;
      csr_crmd_ie = ie; csr_estat_is = is; csr_ecfg_lie = lie;
      csr_eentry = eentry; csr_era = era; redirect_ack = 1'b0;
      @(negedge clk);
      obs_allow_evt = ws_allowin;
      @(posedge clk); #1;
      ws_valid = 1'b0; ws_exc = 5'd0; ws_ertn = 1'b0;
      obs_flush = 0; obs_ex = 0; obs_ertn = 0; obs_ecode = 6'h3F; obs_esub = 9'h1FF;
      obs_pc = 32'hDEADBEEF; obs_vaddr = 32'hDEADBEEF; obs_redir = 32'd0;
      obs_redir_stable = 1'b1; obs_allow_hi = 1'b0; obs_timeout = 1'b0;
      k = 0; done = 1'b0;
      while (!done) begin
         redirect_ack = (k == delay);
         if (k == 1) begin
            csr_eentry = $urandom; csr_era = $urandom;
         end
         @(negedge clk);
         if (wb_ex) obs_ex++;
         if (ertn_flush) obs_ertn++;
         if (wb_ex || ertn_flush) begin
            obs_ecode = wb_ecode; obs_esub = wb_esubcode; obs_pc = wb_pc; obs_vaddr = wb_vaddr;
         end
         if (!flush_req) begin
            done = 1'b1;
            obs_idle_allow = ws_allowin;
         end else begin
            if (k == 0) obs_redir = redirect_pc;
            else if (redirect_pc !== obs_redir) obs_redir_stable = 1'b0;
            if (ws_allowin) obs_allow_hi = 1'b1;
            obs_flush++;
            k++;
            if (k > 60) begin
               done = 1'b1;
               obs_timeout = 1'b1;
               obs_idle_allow = 1'b0;
            end
         end
         @(posedge clk); #1;
         redirect_ack = 1'b0;
      end
   endtask

   task automatic test_reset;
      total++;
      if ({ws_allowin, wb_ex, ertn_flush, flush_req} !== 4'b1000) begin
         bad++;
         $display("FAIL reset_ctrl: got allowin/ex/ertn/flush=%b want 1000",
                  {ws_allowin, wb_ex, ertn_flush, flush_req});
      end
      total++;
      if ({wb_ecode, wb_esubcode, wb_pc, wb_vaddr, redirect_pc} !== 111'd0) begin
         bad++;
         $display("FAIL reset_data: ecode=%h sub=%h pc=%h va=%h rpc=%h want all 0",
                  wb_ecode, wb_esubcode, wb_pc, wb_vaddr, redirect_pc);
      end
   endtask

   task automatic test_brk;
      drive_event(1'b1, 32'h1c000100, 5'b01000, 32'h0, 1'b0, 1'b0, 13'h0, 13'h0,
                  32'h1c008000, 32'h1c00f000, 0);
      total++;
      if (obs_ex !== 1 || obs_ertn !== 0) begin
         bad++; $display("FAIL brk_pulse: ex=%0d ertn=%0d want 1 0", obs_ex, obs_ertn);
      end
      total++;
      if (obs_ecode !== 6'h0C || obs_pc !== 32'h1c000100) begin
         bad++; $display("FAIL brk_code: ecode=%h pc=%h want 0c 1c000100", obs_ecode, obs_pc);
      end
      total++;
      if (obs_redir !== 32'h1c008000) begin
         bad++; $display("FAIL brk_redirect: got %h want 1c008000", obs_redir);
      end
      total++;
      if (obs_flush !== 1 || obs_idle_allow !== 1'b1 || obs_allow_evt !== 1'b0) begin
         bad++; $display("FAIL brk_timing: flush=%0d idle_allow=%b evt_allow=%b want 1 1 0",
                         obs_flush, obs_idle_allow, obs_allow_evt);
      end
   endtask

   task automatic test_ale_ine;
      drive_event(1'b1, 32'h1c000140, 5'b10010, 32'h1234, 1'b0, 1'b0, 13'h0, 13'h0,
                  32'h1c008000, 32'h0, 1);
      total++;
      if (obs_ecode !== 6'h0D || obs_vaddr !== 32'd0) begin
         bad++; $display("FAIL ale_ine: ecode=%h va=%h want 0d 0", obs_ecode, obs_vaddr);
      end
   endtask

   task automatic test_int;
      drive_event(1'b1, 32'h1c000180, 5'b00100, 32'h0, 1'b0, 1'b1, 13'h800, 13'h800,
                  32'h1c008000, 32'h0, 0);
      total++;
      if (obs_ex !== 1 || obs_ecode !== 6'h00) begin
         bad++; $display("FAIL int_taken: ex=%0d ecode=%h want 1 00", obs_ex, obs_ecode);
      end
      drive_event(1'b1, 32'h1c000180, 5'b00100, 32'h0, 1'b0, 1'b0, 13'h800, 13'h800,
                  32'h1c008000, 32'h0, 0);
      total++;
      if (obs_ex !== 1 || obs_ecode !== 6'h0B) begin
         bad++; $display("FAIL int_ie0: ex=%0d ecode=%h want 1 0b", obs_ex, obs_ecode);
      end
      drive_event(1'b1, 32'h1c000180, 5'b00000, 32'h0, 1'b0, 1'b1, 13'h400, 13'h400,
                  32'h1c008000, 32'h0, 0);
      total++;
      if (obs_ex !== 0 || obs_flush !== 0 || obs_allow_evt !== 1'b1) begin
         bad++; $display("FAIL int_bit10: ex=%0d flush=%0d allow=%b want 0 0 1",
                         obs_ex, obs_flush, obs_allow_evt);
      end
      drive_event(1'b0, 32'h1c000180, 5'b00000, 32'h0, 1'b0, 1'b1, 13'h800, 13'h800,
                  32'h1c008000, 32'h0, 0);
      total++;
      if (obs_ex !== 0 || obs_flush !== 0) begin
         bad++; $display("FAIL int_novalid: ex=%0d flush=%0d want 0 0", obs_ex, obs_flush);
      end
   endtask

   task automatic test_ertn_delay;
      drive_event(1'b1, 32'h1c000400, 5'b00000, 32'h0, 1'b1, 1'b0, 13'h0, 13'h0,
                  32'h1c008000, 32'h1c000200, 5);
      total++;
      if (obs_ertn !== 1 || obs_ex !== 0) begin
         bad++; $display("FAIL ertn_pulse: ertn=%0d ex=%0d want 1 0", obs_ertn, obs_ex);
      end
      total++;
      if (obs_flush !== 6 || obs_allow_hi !== 1'b0 || obs_allow_evt !== 1'b0) begin
         bad++; $display("FAIL ertn_hold: flush=%0d allow_hi=%b evt_allow=%b want 6 0 0",
                         obs_flush, obs_allow_hi, obs_allow_evt);
      end
      total++;
      if (obs_redir !== 32'h1c000200 || obs_redir_stable !== 1'b1) begin
         bad++; $display("FAIL ertn_redirect: got %h stable=%b want 1c000200 1",
                         obs_redir, obs_redir_stable);
      end
   endtask

   task automatic test_ertn_adef;
      drive_event(1'b1, 32'h1c000300, 5'b00001, 32'h55, 1'b1, 1'b0, 13'h0, 13'h0,
                  32'h1c008000, 32'h1c000200, 0);
      total++;
      if (obs_ex !== 1 || obs_ertn !== 0 || obs_ecode !== 6'h08 || obs_vaddr !== 32'h1c000300) begin
         bad++; $display("FAIL ertn_adef: ex=%0d ertn=%0d ecode=%h va=%h want 1 0 08 1c000300",
                         obs_ex, obs_ertn, obs_ecode, obs_vaddr);
      end
      total++;
      if (obs_redir !== 32'h1c008000) begin
         bad++; $display("FAIL ertn_adef_redirect: got %h want 1c008000", obs_redir);
      end
   endtask

   task automatic test_reset_midseq;
      int pulses;
      ws_valid = 1'b1; ws_pc = 32'h1c000500; ws_exc = 5'd0; ws_ertn = 1'b1;
      csr_crmd_ie = 1'b0; csr_era = 32'h1c000600; redirect_ack = 1'b0;
      @(posedge clk); #1;
      ws_valid = 1'b0; ws_ertn = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      total++;
      if (flush_req !== 1'b1 || ws_allowin !== 1'b0) begin
         bad++; $display("FAIL midseq_wait: flush=%b allow=%b want 1 0", flush_req, ws_allowin);
      end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      total++;
      if (flush_req !== 1'b0 || ws_allowin !== 1'b1) begin
         bad++; $display("FAIL midseq_reset: flush=%b allow=%b want 0 1", flush_req, ws_allowin);
      end
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (wb_ex || ertn_flush || flush_req) pulses++;
      end
      total++;
      if (pulses !== 0) begin
         bad++; $display("FAIL midseq_quiet: active cycles=%0d want 0", pulses);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_random;
      logic        v, ertn, ie, evt, is_ertn;
      logic [4:0]  exc;
      logic [12:0] is, lie;
      logic [31:0] pc, vaddr, eentry, era, exp_va;
      logic [5:0]  exp_ecode;
      int          delay;
      for (int n = 0; n < 60; n++) begin
         v      = ($urandom_range(0, 9) != 0);
         exc    = ($urandom_range(0, 1) != 0) ? 5'($urandom) : 5'd0;
         ertn   = ($urandom_range(0, 2) == 0);
         ie     = 1'($urandom);
         is     = ($urandom_range(0, 1) != 0) ? 13'($urandom) : 13'd0;
         lie    = 13'($urandom);
         pc     = $urandom & 32'hFFFFFFFC;
         vaddr  = $urandom;
         eentry = $urandom;
         era    = $urandom;
         delay  = $urandom_range(0, 3);
         model(v, exc, ertn, ie, is, lie, pc, vaddr, evt, is_ertn, exp_ecode, exp_va);
         drive_event(v, pc, exc, vaddr, ertn, ie, is, lie, eentry, era, delay);
         total++;
         if (obs_allow_evt !== !evt) begin
            bad++; $display("FAIL rnd%0d_allow: got %b want %b", n, obs_allow_evt, !evt);
         end
         total++;
         if (obs_flush !== (evt ? delay + 1 : 0) || obs_timeout) begin
            bad++; $display("FAIL rnd%0d_flush: got %0d want %0d", n, obs_flush, evt ? delay + 1 : 0);
         end
         total++;
         if (obs_ex !== int'(evt && !is_ertn) || obs_ertn !== int'(is_ertn)) begin
            bad++; $display("FAIL rnd%0d_pulse: ex=%0d ertn=%0d want %0d %0d", n, obs_ex, obs_ertn,
                            int'(evt && !is_ertn), int'(is_ertn));
         end
         total++;
         if (obs_idle_allow !== 1'b1 || obs_allow_hi !== 1'b0) begin
            bad++; $display("FAIL rnd%0d_idle: idle_allow=%b allow_hi=%b want 1 0",
                            n, obs_idle_allow, obs_allow_hi);
         end
         if (evt) begin
            total++;
            if (obs_pc !== pc || obs_esub !== 9'd0 ||
                (!is_ertn && (obs_ecode !== exp_ecode || obs_vaddr !== exp_va))) begin
               bad++; $display("FAIL rnd%0d_data: ecode=%h va=%h pc=%h sub=%h want %h %h %h 0",
                               n, obs_ecode, obs_vaddr, obs_pc, obs_esub, exp_ecode, exp_va, pc);
            end
            total++;
            if (obs_redir !== (is_ertn ? era : eentry) || obs_redir_stable !== 1'b1) begin
               bad++; $display("FAIL rnd%0d_redirect: got %h stable=%b want %h", n, obs_redir,
                               obs_redir_stable, is_ertn ? era : eentry);
            end
         end
      end
   endtask

   initial begin
      total = 0; bad = 0;
      reset = 1'b1; ws_valid = 1'b0; ws_pc = 32'd0; ws_exc = 5'd0; ws_vaddr = 32'd0;
      ws_ertn = 1'b0; csr_crmd_ie = 1'b0; csr_estat_is = 13'd0; csr_ecfg_lie = 13'd0;
      csr_eentry = 32'd0; csr_era = 32'd0; redirect_ack = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      test_reset;
      @(posedge clk); #1;
      test_brk;
      test_ale_ine;
      test_int;
      test_ertn_delay;
      test_ertn_adef;
      test_reset_midseq;
      test_random;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
